mem_port_arbiter: RTL and testbench

Shares the memory's synchronous read port (port 1) and its write port between two requesters: the CPU load/store unit and a DMA/blitter engine. It sits directly in front of `mem`, with the CPU instruction-fetch port (port 0) untouched. Arbitration and ack happen in the same cycle as the request. Read data returns one cycle later and is steered to the requester that issued the read. Accesses are pipelined: one access per cycle, no bubbles.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the memory's synchronous read port (port 1) and its write port
// between the CPU load/store unit and the DMA/blitter engine. Grant and ack
// are combinational in the request cycle. Read data comes back one cycle
// later and is steered to whichever requester issued the read. One access
// per cycle, no bubbles.
//
// Optional build macro: MEM_ARB_STARVE_GUARD_EN
//   undefined : strict CPU priority (DMA wins only when the CPU is idle or
//               while the DMA holds a lock)
//   defined   : after STREAK_MAX consecutive CPU grants with the DMA waiting,
//               the DMA is given one slot
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width
//   STREAK_MAX  CPU grants allowed while the DMA waits (guard build), 1..15
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   cpu_req/we/addr/wdata -> cpu_ack    CPU request, accepted this cycle
//   cpu_rvalid, cpu_rdata               CPU read return (1 cycle after ack)
//   dma_req/we/addr/wdata -> dma_ack    DMA request, accepted this cycle
//   dma_lock                            DMA keeps ownership across beats
//   dma_rvalid, dma_rdata               DMA read return (1 cycle after ack)
//   mem_ren, mem_raddr                  to mem ren / raddr1
//   mem_wen, mem_waddr, mem_wdata       to mem wen / waddr / wdata
//   mem_rdata                           from mem rdata1
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_IDLE     | no owner, nothing granted last cycle
// ST_CPU_OWN  | last grant went to the CPU
// ST_DMA_OWN  | last grant went to the DMA without lock
// ST_DMA_LOCK | last grant went to the DMA with dma_lock = 1

module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_ack,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,

  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_OWN  = 2'd1,
    ST_DMA_OWN  = 2'd2,
    ST_DMA_LOCK = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic   cpu_win;
  logic   dma_win;
  logic   guard_act;

  // Read-return tracking: rd_owner = 1 means the DMA issued the read.
  logic   rd_pend;
  logic   rd_owner;

  // Out-of-range STREAK_MAX would make the 4-bit streak compare meaningless.
  if (STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_streak_max_range
    $error("mem_port_arbiter: STREAK_MAX must be within 1..15");
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

  logic [3:0] cpu_streak;

  assign guard_act = dma_req && (cpu_streak == STREAK_LIM);

  // Counts CPU wins only while the DMA is actually waiting; any DMA grant or
  // a cycle without a DMA request starts the count over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_streak <= 4'd0;
    end else if (dma_win || !dma_req) begin
      cpu_streak <= 4'd0;
    end else if (cpu_win && (cpu_streak != 4'hF)) begin
      cpu_streak <= cpu_streak + 4'd1;
    end
  end
`else
  assign guard_act = 1'b0;
`endif

  // Grant, next state and memory steering.
  always_comb begin
    cpu_win   = 1'b0;
    dma_win   = 1'b0;
    state_nxt = ST_IDLE;
    mem_ren   = 1'b0;
    mem_raddr = '0;
    mem_wen   = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;

    // A locked DMA keeps the port for as long as it keeps requesting; the
    // lock bit itself only matters on a beat the DMA actually wins.
    if (dma_req && ((state == ST_DMA_LOCK) || guard_act || !cpu_req)) begin
      dma_win = 1'b1;
    end else if (cpu_req) begin
      cpu_win = 1'b1;
    end

    if (dma_win) begin
      state_nxt = dma_lock ? ST_DMA_LOCK : ST_DMA_OWN;
      mem_ren   = !dma_we;
      mem_raddr = dma_addr;
      mem_wen   = dma_we;
      mem_waddr = dma_addr;
      mem_wdata = dma_wdata;
    end else if (cpu_win) begin
      state_nxt = ST_CPU_OWN;
      mem_ren   = !cpu_we;
      mem_raddr = cpu_addr;
      mem_wen   = cpu_we;
      mem_waddr = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= mem_ren;
      if (mem_ren) begin
        rd_owner <= dma_win;
      end
    end
  end

  assign cpu_ack    = cpu_win;
  assign dma_ack    = dma_win;

  // Data fans out to both requesters; only the owner sees rvalid.
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign cpu_rvalid = rd_pend && !rd_owner;
  assign dma_rvalid = rd_pend &&  rd_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_ack, cpu_rvalid;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_lock, dma_ack, dma_rvalid;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_ren, mem_wen;
  logic [15:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;

  int n_chk;
  int n_err;

  typedef struct packed {
    logic        vc;
    logic        vd;
    logic [15:0] data;
  } rd_exp_t;

  rd_exp_t     sb[$];
  logic [15:0] mem_wr[int];
  logic [15:0] ref_wr[int];

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STREAK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return a ^ 16'hA5C3;
  endfunction

  // Synchronous memory, read-old on a same-edge write.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem_wr.exists(int'(mem_raddr)) ? mem_wr[int'(mem_raddr)]
                                                             : init_val(mem_raddr);
    if (mem_wen) mem_wr[int'(mem_waddr)] = mem_wdata;
  end

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_wr.exists(int'(a)) ? ref_wr[int'(a)] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [15:0] caddr,
                       input logic [15:0] cwd, input logic dreq, input logic dwe,
                       input logic [15:0] daddr, input logic [15:0] dwd, input logic dlk);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd; dma_lock = dlk;
  endtask

  // One cycle: check acks and mem steering, retire the read expected from the
  // previous cycle, then record what this cycle should return.
  task automatic step(input string tag, input logic exp_c, input logic exp_d);
    rd_exp_t     e;
    rd_exp_t     nxt;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
    @(negedge clk);
    we   = exp_c ? cpu_we    : (exp_d ? dma_we    : 1'b0);
    addr = exp_c ? cpu_addr  : (exp_d ? dma_addr  : 16'h0);
    wd   = exp_c ? cpu_wdata : (exp_d ? dma_wdata : 16'h0);
    chk({tag, " cpu_ack"}, 16'(cpu_ack), 16'(exp_c));
    chk({tag, " dma_ack"}, 16'(dma_ack), 16'(exp_d));
    chk({tag, " mem_ren"}, 16'(mem_ren), 16'((exp_c | exp_d) & ~we));
    chk({tag, " mem_wen"}, 16'(mem_wen), 16'(we));
    chk({tag, " mem_raddr"}, mem_raddr, addr);
    chk({tag, " mem_waddr"}, mem_waddr, addr);
    chk({tag, " mem_wdata"}, mem_wdata, wd);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " cpu_rvalid"}, 16'(cpu_rvalid), 16'(e.vc));
      chk({tag, " dma_rvalid"}, 16'(dma_rvalid), 16'(e.vd));
      if (e.vc) chk({tag, " cpu_rdata"}, cpu_rdata, e.data);
      if (e.vd) chk({tag, " dma_rdata"}, dma_rdata, e.data);
    end
    nxt = '0;
    if ((exp_c | exp_d) && !we) begin
      nxt.vc   = exp_c;
      nxt.vd   = exp_d;
      nxt.data = ref_rd(addr);
    end
    if ((exp_c | exp_d) && we) ref_wr[int'(addr)] = wd;
    sb.push_back(nxt);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step(tag, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_d;
    n_chk = 0;
    n_err = 0;

    // Reset with both requesters active: grant is still combinational.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 16'h0011, 16'h0, 1'b1, 1'b0, 16'h0022, 16'h0, 1'b0);
    #3;
    chk("rst cpu_ack", 16'(cpu_ack), 16'd1);
    chk("rst dma_ack", 16'(dma_ack), 16'd0);
    chk("rst mem_raddr", mem_raddr, 16'h0011);
    repeat (2) @(posedge clk);
    #1;
    chk("rst cpu_rvalid", 16'(cpu_rvalid), 16'd0);
    chk("rst dma_rvalid", 16'(dma_rvalid), 16'd0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('0);
    idle("post_rst");

    // Single CPU read.
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step("rd", 1'b1, 1'b0);
    idle("rd_ret");

    // Both requesting for 10 cycles; DMA holds its request unchanged.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 16'h0100 + 16'(i), 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0, 1'b0);
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_d = (i == 4) || (i == 9);
`else
      exp_d = 1'b0;
`endif
      step($sformatf("prio%0d", i), ~exp_d, exp_d);
    end
    idle("prio_end");

    // Unlocked DMA grant does not hold off the CPU next cycle.
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0300, 16'h0, 1'b0);
    step("nolock_d", 1'b0, 1'b1);
    drive(1'b1, 1'b0, 16'h0301, 16'h0, 1'b1, 1'b0, 16'h0302, 16'h0, 1'b0);
    step("nolock_c", 1'b1, 1'b0);
    idle("nolock_end");

    // Locked DMA write burst to 0xE000..0xE002 with the CPU waiting.
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'hE000, 16'hD000, 1'b1);
    step("lock0", 1'b0, 1'b1);
    for (int i = 1; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'hE001, 16'h0, 1'b1, 1'b1, 16'hE000 + 16'(i), 16'hD000 + 16'(i), 1'b1);
      step($sformatf("lock%0d", i), 1'b0, 1'b1);
    end
    drive(1'b1, 1'b0, 16'hE001, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step("lock_rel", 1'b1, 1'b0);
    idle("lock_end");

    // Mixed pipeline: CPU read then DMA read back to back.
    drive(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step("mix_c", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'hC000, 16'h0, 1'b0);
    step("mix_d", 1'b0, 1'b1);
    idle("mix_ret");

    // Write (no rvalid), then read-after-write from each side.
    drive(1'b1, 1'b1, 16'h0040, 16'h1357, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step("wr", 1'b1, 1'b0);
    drive(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step("raw_c", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0);
    step("raw_d", 1'b0, 1'b1);
    idle("raw_ret");

    // Reset right after a read is acked drops the return.
    drive(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step("mid_rd", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst cpu_rvalid", 16'(cpu_rvalid), 16'd0);
    chk("mid_rst dma_rvalid", 16'(dma_rvalid), 16'd0);
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('0);
    idle("mid_end");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
